// File: rtl/imem_loader.sv
// Boot loader: frames a byte stream (sync, 16-bit word count, little-endian words) into instruction RAM writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before the CPU is released.
module imem_loader #(
   parameter int         ADDR_WIDTH = 10,
   parameter int         MAX_WORDS  = 256,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        mem_we,
   output logic [31:0] mem_address,
   output logic [31:0] mem_data,
   output logic        cpu_reset,
   output logic        done,
   output logic        error
);

   localparam int IW = ADDR_WIDTH - 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE,
      S_ERROR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   count_q, count_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [1:0]    lane_q, lane_d;
   logic [23:0]   word_q, word_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_address_q, mem_address_d;
   logic [31:0]   mem_data_q, mem_data_d;
   logic          rx_ready_q, rx_ready_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    csum_q, csum_d;
`endif

   logic        fire;
   logic [15:0] cnt_in;

   assign fire   = rx_valid & rx_ready_q;
   assign cnt_in = {rx_data, count_q[7:0]};

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      idx_d         = idx_q;
      lane_d        = lane_q;
      word_d        = word_q;
      mem_we_d      = 1'b0;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d        = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (fire && rx_data == SYNC_BYTE) state_d = S_CNT_LO;
         end
         S_CNT_LO: begin
            if (fire) begin
               count_d[7:0] = rx_data;
               state_d      = S_CNT_HI;
            end
         end
         S_CNT_HI: begin
            if (fire) begin
               count_d = cnt_in;
               if (cnt_in == 16'd0 || cnt_in > 16'(MAX_WORDS)) begin
                  state_d = S_ERROR;
               end else begin
                  state_d = S_DATA;
                  idx_d   = '0;
                  lane_d  = 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_d  = 8'd0;
`endif
               end
            end
         end
         S_DATA: begin
            if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ rx_data;
`endif
               case (lane_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  default: begin
                     mem_we_d      = 1'b1;
                     mem_data_d    = {rx_data, word_q};
                     mem_address_d = 32'({idx_q, 2'b00});
                     idx_d         = idx_q + 1'b1;
                  end
               endcase
               lane_d = lane_q + 2'd1;
               // Last word of the image: the count was range-checked, so count_q-1 fits the index.
               if (lane_q == 2'd3 && 16'(idx_q) == count_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (fire) state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
         end
`endif
         default: ;
      endcase

      // Status lags state by a cycle so the final write lands before the CPU is released.
      done_d      = done_q | (state_q == S_DONE);
      cpu_reset_d = cpu_reset_q & (state_q != S_DONE);
      error_d     = error_q | (state_q == S_ERROR);
      rx_ready_d  = (state_d != S_DONE) && (state_d != S_ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         count_q       <= '0;
         idx_q         <= '0;
         lane_q        <= '0;
         word_q        <= '0;
         mem_we_q      <= 1'b0;
         mem_address_q <= '0;
         mem_data_q    <= '0;
         rx_ready_q    <= 1'b1;
         cpu_reset_q   <= 1'b1;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         idx_q         <= idx_d;
         lane_q        <= lane_d;
         word_q        <= word_d;
         mem_we_q      <= mem_we_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         rx_ready_q    <= rx_ready_d;
         cpu_reset_q   <= cpu_reset_d;
         done_q        <= done_d;
         error_q       <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q        <= csum_d;
`endif
      end
   end

   assign rx_ready    = rx_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign cpu_reset   = cpu_reset_q;
   assign done        = done_q;
   assign error       = error_q;

endmodule
